// File: rtl/atx_uart_pkg.sv
// atx_uart_pkg: shared FSM encoding and widths for the atx_uart_tx transmitter
package atx_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} atx_state_t;
  localparam int ATX_DIV_W = 16;
  localparam int ATX_FRAME_BITS = 10;
endpackage

// File: rtl/atx_uart_tx_fifo.sv
// atx_tx_fifo: transmit buffer, a circular FIFO under ATX_UART_FIFO_EN, else a single holding register
module atx_tx_fifo
`ifdef ATX_UART_FIFO_EN
#(
  parameter int DEPTH_LOG2 = 2
)
`endif
(
  input  logic       sysclk,
  input  logic       sysreset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic       overflow
);
  logic push_ok;
  assign push_ok = push & ~full;
  assign overflow = push & full;
`ifdef ATX_UART_FIFO_EN
  logic [7:0] mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr, rd, wr_n, rd_n;
  assign wr_n = wr + (DEPTH_LOG2 + 1)'(push_ok);
  assign rd_n = rd + (DEPTH_LOG2 + 1)'(pop & ~empty);
  assign empty = wr == rd;
  assign dout = mem[rd[DEPTH_LOG2-1:0]];
  // full is registered from the next pointers so tx_busy comes straight off a flop
  always_ff @(posedge sysclk or negedge sysreset_n)
    if (!sysreset_n) begin
      wr <= '0;
      rd <= '0;
      full <= 1'b0;
    end else begin
      wr <= wr_n;
      rd <= rd_n;
      full <= (wr_n ^ rd_n) == {1'b1, {DEPTH_LOG2{1'b0}}};
    end
  always_ff @(posedge sysclk)
    if (push_ok) mem[wr[DEPTH_LOG2-1:0]] <= din;
`else
  logic [7:0] hold;
  assign empty = ~full;
  assign dout = hold;
  always_ff @(posedge sysclk or negedge sysreset_n)
    if (!sysreset_n) full <= 1'b0;
    else full <= push_ok | (full & ~pop);
  always_ff @(posedge sysclk)
    if (push_ok) hold <= din;
`endif
endmodule

// File: rtl/atx_uart_tx.sv
// atx_uart_tx: 8N1 UART transmitter with internal bit divider; ATX_UART_FIFO_EN enables a FIFO buffer
module atx_uart_tx
  import atx_uart_pkg::*;
#(
  parameter int DIVISOR = 434
`ifdef ATX_UART_FIFO_EN
  , parameter int DEPTH_LOG2 = 2
`endif
) (
  input  logic       sysclk,
  input  logic       sysreset_n,
  input  logic [7:0] parallel_in,
  input  logic       load_data,
  output logic       tx_line,
  output logic       tx_busy,
  output logic       tx_active,
  output logic       overflow
);
  localparam logic [ATX_DIV_W-1:0] DIV_LAST = ATX_DIV_W'(DIVISOR - 1);
  atx_state_t state, state_n;
  logic [ATX_DIV_W-1:0] div, div_n;
  logic [2:0] bcnt, bcnt_n;
  logic [7:0] shift, shift_n, fifo_dout;
  logic load_q, push, pop, empty, full, ovf, tx_line_n, bit_end;
  assign push = load_data & ~load_q;
  assign bit_end = div == '0;
  assign tx_busy = full;
  assign tx_active = state != IDLE;
  atx_tx_fifo
`ifdef ATX_UART_FIFO_EN
    #(.DEPTH_LOG2(DEPTH_LOG2))
`endif
    u_fifo (
      .sysclk(sysclk),
      .sysreset_n(sysreset_n),
      .push(push),
      .pop(pop),
      .din(parallel_in),
      .dout(fifo_dout),
      .full(full),
      .empty(empty),
      .overflow(ovf)
    );
  always_comb begin
    state_n = state;
    div_n = bit_end ? div : div - 1'b1;
    bcnt_n = bcnt;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: pop = ~empty;
      START: if (bit_end) begin
        state_n = DATA;
        div_n = DIV_LAST;
      end
      DATA: if (bit_end) begin
        div_n = DIV_LAST;
        shift_n = shift >> 1;
        bcnt_n = bcnt + 1'b1;
        if (bcnt == 3'd7) state_n = STOP;
      end
      STOP: if (bit_end) begin
        pop = ~empty;
        state_n = IDLE;
      end
      default: ;
    endcase
    // a pop from IDLE or the end of STOP both launch the next start bit
    if (pop) begin
      state_n = START;
      shift_n = fifo_dout;
      bcnt_n = '0;
      div_n = DIV_LAST;
    end
    tx_line_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
  always_ff @(posedge sysclk or negedge sysreset_n)
    if (!sysreset_n) begin
      state <= IDLE;
      div <= '0;
      bcnt <= '0;
      shift <= '0;
      load_q <= 1'b0;
      tx_line <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      div <= div_n;
      bcnt <= bcnt_n;
      shift <= shift_n;
      load_q <= load_data;
      tx_line <= tx_line_n;
      overflow <= overflow | ovf;
    end
endmodule

// File: tb/tb_atx_uart_tx.sv
// tb_atx_uart_tx: directed self-checking bench for atx_uart_tx at DIVISOR=4
module tb_atx_uart_tx;
  import atx_uart_pkg::*;
  localparam int DIV = 4;
  localparam bit FIFO_ON =
`ifdef ATX_UART_FIFO_EN
    1'b1;
`else
    1'b0;
`endif
  logic sysclk = 1'b0;
  logic sysreset_n = 1'b0;
  logic load_data = 1'b0;
  logic [7:0] parallel_in = 8'h00;
  logic tx_line, tx_busy, tx_active, overflow;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rx [$];
  logic [7:0] rx_b;

  always #5 sysclk = ~sysclk;

  atx_uart_tx #(
    .DIVISOR(DIV)
`ifdef ATX_UART_FIFO_EN
    , .DEPTH_LOG2(2)
`endif
  ) dut (
    .sysclk(sysclk),
    .sysreset_n(sysreset_n),
    .parallel_in(parallel_in),
    .load_data(load_data),
    .tx_line(tx_line),
    .tx_busy(tx_busy),
    .tx_active(tx_active),
    .overflow(overflow)
  );

  // independent line receiver: samples each bit at its centre on the falling clock
  initial forever begin
    @(negedge sysclk);
    if (sysreset_n === 1'b1 && tx_line === 1'b0) begin
      repeat (DIV / 2) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge sysclk);
        rx_b[i] = tx_line;
      end
      repeat (DIV) @(negedge sysclk);
      if (tx_line === 1'b1) rx.push_back(rx_b);
      repeat (DIV / 2 - 1) @(negedge sysclk);
    end
  end

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    logic [ATX_FRAME_BITS-1:0] f;
    f = {1'b1, b, 1'b0};
    return f[k / DIV];
  endfunction

  task automatic test_reset;
    sysreset_n = 1'b0;
    parallel_in = 8'h5A;
    load_data = 1'b1;
    repeat (3) tick;
    n_cmp++; if (tx_line !== 1'b1) begin n_bad++; $display("FAIL reset_line: got %b want 1", tx_line); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_cmp++; if (tx_active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b want 0", tx_active); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    sysreset_n = 1'b1;
    tick;
    tick;
    n_cmp++; if (tx_line !== 1'b0) begin n_bad++; $display("FAIL release_load_start: got %b want 0", tx_line); end
    load_data = 1'b0;
    repeat (45) tick;
    n_cmp++;
    if (rx.size() != 1 || rx[0] !== 8'h5A) begin
      n_bad++; $display("FAIL release_load_rx: got %0d bytes first %h want 1 byte 5a", rx.size(), rx[0]);
    end
    rx.delete();
  endtask

  task automatic test_single_frame;
    int e_line, n_act;
    e_line = 0;
    n_act = 0;
    parallel_in = 8'h55;
    load_data = 1'b1;
    tick;
    n_cmp++; if (tx_line !== 1'b1) begin n_bad++; $display("FAIL single_pre_start: got %b want 1", tx_line); end
    n_cmp++; if (tx_busy !== !FIFO_ON) begin n_bad++; $display("FAIL single_busy_push: got %b want %b", tx_busy, !FIFO_ON); end
    load_data = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick;
      if (tx_line !== (k < 40 ? fbit(8'h55, k) : 1'b1)) e_line++;
      if (tx_active === 1'b1) n_act++;
    end
    n_cmp++; if (e_line != 0) begin n_bad++; $display("FAIL single_line: %0d wrong samples want 0", e_line); end
    n_cmp++; if (n_act != 40) begin n_bad++; $display("FAIL single_active: %0d cycles want 40", n_act); end
    n_cmp++;
    if (rx.size() != 1 || rx[0] !== 8'h55) begin
      n_bad++; $display("FAIL single_rx: got %0d bytes first %h want 1 byte 55", rx.size(), rx[0]);
    end
    rx.delete();
  endtask

  task automatic test_hold_high;
    parallel_in = 8'h3C;
    load_data = 1'b1;
    repeat (100) tick;
    load_data = 1'b0;
    repeat (60) tick;
    n_cmp++;
    if (rx.size() != 1 || rx[0] !== 8'h3C) begin
      n_bad++; $display("FAIL hold_rx: got %0d bytes first %h want 1 byte 3c", rx.size(), rx[0]);
    end
    rx.delete();
  endtask

  task automatic test_back_to_back;
    int e_line, e_busy;
    logic eb;
    e_line = 0;
    e_busy = 0;
    for (int j = 0; j <= 95; j++) begin
      load_data = j == 0 || j == 6;
      parallel_in = j == 0 ? 8'h80 : 8'h7F;
      tick;
      if (j >= 1) begin
        if (tx_line !== (j <= 40 ? fbit(8'h80, j - 1) : j <= 80 ? fbit(8'h7F, j - 41) : 1'b1)) e_line++;
        eb = !FIFO_ON && j >= 6 && j <= 40;
        if (tx_busy !== eb) e_busy++;
      end
    end
    load_data = 1'b0;
    n_cmp++; if (e_line != 0) begin n_bad++; $display("FAIL b2b_line: %0d wrong samples want 0", e_line); end
    n_cmp++; if (e_busy != 0) begin n_bad++; $display("FAIL b2b_busy: %0d wrong samples want 0", e_busy); end
    n_cmp++;
    if (rx.size() != 2 || rx[0] !== 8'h80 || rx[1] !== 8'h7F) begin
      n_bad++; $display("FAIL b2b_rx: got %0d bytes first %h want 80 7f", rx.size(), rx[0]);
    end
    rx.delete();
  endtask

  task automatic test_burst;
    int r, e_line, e_busy, bad;
    logic eb;
    r = FIFO_ON ? 5 : 2;
    e_line = 0;
    e_busy = 0;
    bad = 0;
    for (int j = 0; j <= 40 * r + 20; j++) begin
      load_data = (j % 2 == 0) && (j / 2 < r);
      parallel_in = 8'(8'h01 + j / 2);
      tick;
      if (j >= 1) begin
        if (tx_line !== (j <= 40 * r ? fbit(8'(8'h01 + (j - 1) / 40), (j - 1) % 40) : 1'b1)) e_line++;
        eb = j >= 2 * (r - 1) && j <= 40;
        if (tx_busy !== eb) e_busy++;
      end
    end
    load_data = 1'b0;
    n_cmp++; if (e_line != 0) begin n_bad++; $display("FAIL burst_line: %0d wrong samples want 0", e_line); end
    n_cmp++; if (e_busy != 0) begin n_bad++; $display("FAIL burst_busy: %0d wrong samples want 0", e_busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL burst_overflow: got %b want 0", overflow); end
    if (rx.size() != r) bad = 1;
    for (int i = 0; i < r && i < rx.size(); i++) if (rx[i] !== 8'(8'h01 + i)) bad = 1;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL burst_rx: got %0d bytes want %0d bytes 01 upward", rx.size(), r); end
    rx.delete();
  endtask

  task automatic test_overflow;
    int r, e_line, e_ovf, bad;
    r = FIFO_ON ? 6 : 3;
    e_line = 0;
    e_ovf = 0;
    bad = 0;
    for (int j = 0; j <= 40 * (r - 1) + 20; j++) begin
      load_data = (j % 2 == 0) && (j / 2 < r);
      parallel_in = 8'(8'h11 + j / 2);
      tick;
      if (j >= 1) begin
        if (tx_line !== (j <= 40 * (r - 1) ? fbit(8'(8'h11 + (j - 1) / 40), (j - 1) % 40) : 1'b1)) e_line++;
        if (overflow !== (j >= 2 * (r - 1))) e_ovf++;
      end
    end
    load_data = 1'b0;
    n_cmp++; if (e_line != 0) begin n_bad++; $display("FAIL ovf_line: %0d wrong samples want 0", e_line); end
    n_cmp++; if (e_ovf != 0) begin n_bad++; $display("FAIL ovf_flag: %0d wrong samples want 0", e_ovf); end
    if (rx.size() != r - 1) bad = 1;
    for (int i = 0; i < r - 1 && i < rx.size(); i++) if (rx[i] !== 8'(8'h11 + i)) bad = 1;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ovf_rx: got %0d bytes want %0d bytes 11 upward", rx.size(), r - 1); end
    rx.delete();
  endtask

  task automatic test_reset_mid;
    int q, n_err;
    logic [7:0] bytes [3];
    bytes[0] = 8'hA3;
    bytes[1] = 8'h01;
    bytes[2] = 8'h02;
    q = FIFO_ON ? 3 : 2;
    for (int j = 0; j <= 18; j++) begin
      load_data = (j % 2 == 0) && (j / 2 < q);
      parallel_in = bytes[j / 2 < 3 ? j / 2 : 2];
      tick;
    end
    load_data = 1'b0;
    n_cmp++; if (tx_line !== 1'b0) begin n_bad++; $display("FAIL mid_bit3: got %b want 0", tx_line); end
    sysreset_n = 1'b0;
    #1;
    n_cmp++; if (tx_line !== 1'b1) begin n_bad++; $display("FAIL mid_reset_line: got %b want 1", tx_line); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", tx_busy); end
    n_cmp++; if (tx_active !== 1'b0) begin n_bad++; $display("FAIL mid_reset_active: got %b want 0", tx_active); end
    repeat (3) tick;
    sysreset_n = 1'b1;
    n_err = 0;
    for (int k = 0; k < 100; k++) begin
      tick;
      if (tx_line !== 1'b1 || tx_active !== 1'b0) n_err++;
    end
    n_cmp++; if (n_err != 0) begin n_bad++; $display("FAIL mid_no_resume: %0d active samples want 0", n_err); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_overflow: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_hold_high;
    test_back_to_back;
    test_burst;
    test_overflow;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
